// File: rtl/fft_64p_16b_out_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_64p_pkg  (file fft_64p_16b_out_buffer_pkg.sv)
//  Purpose  : Shared constants, FSM state encodings and the 6-bit
//             bit-reverse helper for the FFT output buffer slice.
//  Contents : FFT_N, FFT_N_LOG2, FFT_DATA_W, wr_state_t, rd_state_t,
//             bitrev6()
//  Revision : 1.0  initial release
// ============================================================================
package fft_64p_pkg;

  localparam int FFT_N      = 64;
  localparam int FFT_N_LOG2 = 6;
  localparam int FFT_DATA_W = 32;

  // Write side: capturing a burst, or swallowing one that has nowhere to go.
  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_CAPT = 2'd1,
    W_DROP = 2'd2
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  function automatic logic [5:0] bitrev6(input logic [5:0] a);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = a[5-i];
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fft_64p_16b_out_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fft_64p_16b_out_buffer_if
//  Purpose  : Bundles the FFT result stream (input side) and the
//             valid/ready frame stream plus status (output side).
//  Modports : master - the buffer: takes Data_Out/Out_Stream/m_ready,
//                      drives m_data/m_valid/m_index/m_last/ovf_err/
//                      frames_lost
//             slave  - the environment: the mirror image
//  Revision : 1.0  initial release
// ============================================================================
interface fft_64p_16b_out_buffer_if;
  import fft_64p_pkg::*;

  logic                  Data_Out;
  logic [FFT_DATA_W-1:0] Out_Stream;
  logic [FFT_DATA_W-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [FFT_N_LOG2-1:0] m_index;
  logic                  m_last;
  logic                  ovf_err;
  logic [7:0]            frames_lost;

  modport master (
    input  Data_Out, Out_Stream, m_ready,
    output m_data, m_valid, m_index, m_last, ovf_err, frames_lost
  );

  modport slave (
    output Data_Out, Out_Stream, m_ready,
    input  m_data, m_valid, m_index, m_last, ovf_err, frames_lost
  );

endinterface
`default_nettype wire

// File: rtl/fft_64p_16b_out_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fft_dp_ram_64x32
//  Purpose  : Simple dual-port RAM, one write port, one registered read
//             port (read data valid the cycle after i_re).
//  Ports    : clk, i_we/i_waddr/i_wdata (write), i_re/i_raddr (read),
//             o_rdata (registered read data, holds when i_re is low)
//  Revision : 1.0  initial release
// ============================================================================
module fft_dp_ram_64x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  wire logic              clk,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_re,
  input  wire logic [ADDR_W-1:0] i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/fft_64p_16b_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_64p_16b_out_buffer
//  Purpose  : Captures 64-word FFT result bursts into two ping-pong banks
//             and drains whole frames to a back-pressuring consumer.
//  Ports    : clk, rst_n (async, active low),
//             bus (master): Data_Out/Out_Stream in, m_ready in,
//             m_data/m_valid/m_index/m_last/ovf_err/frames_lost out
//  Options  : FFT_OUT_BITREV_EN - drain each bank in bit-reversed address
//             order so the frame leaves in natural order.
//  Revision : 1.0  initial release
// ============================================================================
module fft_64p_16b_out_buffer
  import fft_64p_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int N_LOG2 = FFT_N_LOG2
) (
  input wire logic               clk,
  input wire logic               rst_n,
  fft_64p_16b_out_buffer_if.master bus
);

  localparam logic [N_LOG2-1:0] c_last_idx = N_LOG2'(FFT_N - 1);
  localparam logic [N_LOG2-1:0] c_one      = N_LOG2'(1);

  // ---------------- state ----------------
  wr_state_t         r_wstate, w_wstate_nxt;
  logic              r_wbank;
  logic [N_LOG2-1:0] r_wcnt;
  logic [1:0]        r_full;
  logic [7:0]        r_lost;

  rd_state_t         r_rstate, w_rstate_nxt;
  logic              r_rbank;
  logic [N_LOG2-1:0] r_rcnt;
  logic              r_issued_all;

  logic              r_q_valid;     // RAM read register holds a word
  logic [N_LOG2-1:0] r_q_idx;
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [N_LOG2-1:0] r_m_index;
  logic              r_m_last;

  logic              w_we, w_cap_done, w_drop, w_re, w_release, w_wr_free;
  logic              w_adv_a, w_adv_b;
  logic [N_LOG2-1:0] w_waddr, w_raddr_nat, w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_bank_rdata [2];

  // Releasing a bank frees it in the same cycle for a new burst start.
  assign w_release = r_m_valid & bus.m_ready & r_m_last;
  assign w_wr_free = ~r_full[r_wbank] | (w_release & (r_rbank == r_wbank));

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_we         = 1'b0;
    w_waddr      = r_wcnt;
    w_cap_done   = 1'b0;
    w_drop       = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (bus.Data_Out) begin
          if (w_wr_free) begin
            w_we         = 1'b1;
            w_waddr      = '0;
            w_wstate_nxt = W_CAPT;
          end else begin
            w_drop       = 1'b1;
            w_wstate_nxt = W_DROP;
          end
        end
      end
      W_CAPT: begin
        w_we = 1'b1;
        if (r_wcnt == c_last_idx) begin
          w_cap_done   = 1'b1;
          w_wstate_nxt = W_IDLE;
        end
      end
      W_DROP: begin
        if (r_wcnt == c_last_idx) w_wstate_nxt = W_IDLE;
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate <= W_IDLE;
      r_wcnt   <= '0;
      r_wbank  <= 1'b0;
      r_lost   <= '0;
    end else begin
      r_wstate <= w_wstate_nxt;
      // Counter wraps 63->0 at the end of both capture and drop.
      if (r_wstate == W_IDLE) r_wcnt <= bus.Data_Out ? c_one : '0;
      else                    r_wcnt <= r_wcnt + c_one;
      if (w_cap_done) r_wbank <= ~r_wbank;
      if (w_drop && r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
    end
  end

  // Bank state bits: the only interlock between the two sides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      if (w_cap_done) r_full[r_wbank] <= 1'b1;
      if (w_release)  r_full[r_rbank] <= 1'b0;
    end
  end

  // ---------------- read FSM ----------------
  // Two-stage pipe: RAM read register (stage A) feeding the output
  // register (stage B); A refills whenever B moves, so beats are gap-free.
  assign w_adv_b = ~r_m_valid | bus.m_ready;
  assign w_adv_a = ~r_q_valid | w_adv_b;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_re         = 1'b0;
    w_raddr_nat  = r_rcnt;
    case (r_rstate)
      R_IDLE: begin
        if (r_full[r_rbank] && w_adv_a) begin
          w_re         = 1'b1;
          w_raddr_nat  = '0;
          w_rstate_nxt = R_DRAIN;
        end
      end
      R_DRAIN: begin
        w_re = ~r_issued_all & w_adv_a;
        if (w_release) w_rstate_nxt = R_IDLE;
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

`ifdef FFT_OUT_BITREV_EN
  assign w_raddr = bitrev6(w_raddr_nat);
`else
  assign w_raddr = w_raddr_nat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate     <= R_IDLE;
      r_rbank      <= 1'b0;
      r_rcnt       <= '0;
      r_issued_all <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_re) begin
        r_rcnt       <= w_raddr_nat + c_one;
        r_issued_all <= (w_raddr_nat == c_last_idx);
      end
      if (w_release) r_rbank <= ~r_rbank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid <= 1'b0;
      r_q_idx   <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_index <= '0;
      r_m_last  <= 1'b0;
    end else begin
      if (w_adv_a) begin
        r_q_valid <= w_re;
        if (w_re) r_q_idx <= w_raddr_nat;
      end
      if (w_adv_b) begin
        r_m_valid <= r_q_valid;
        r_m_last  <= r_q_valid & (r_q_idx == c_last_idx);
        if (r_q_valid) begin
          r_m_data  <= w_rdata;
          r_m_index <= r_q_idx;
        end
      end
    end
  end

  // ---------------- banks ----------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_dp_ram_64x32 #(.DATA_W(DATA_W), .ADDR_W(N_LOG2)) u_ram (
      .clk     (clk),
      .i_we    (w_we & (r_wbank == 1'(b))),
      .i_waddr (w_waddr),
      .i_wdata (bus.Out_Stream),
      .i_re    (w_re & (r_rbank == 1'(b))),
      .i_raddr (w_raddr),
      .o_rdata (w_bank_rdata[b])
    );
  end

  // The read bank cannot change while stage A holds a word.
  assign w_rdata = r_rbank ? w_bank_rdata[1] : w_bank_rdata[0];

  assign bus.m_data      = r_m_data;
  assign bus.m_valid     = r_m_valid;
  assign bus.m_index     = r_m_index;
  assign bus.m_last      = r_m_last;
  assign bus.ovf_err     = w_drop;
  assign bus.frames_lost = r_lost;

endmodule
`default_nettype wire

// File: tb/tb_fft_64p_16b_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_64p_16b_out_buffer
//  Purpose  : Directed self-checking bench for fft_64p_16b_out_buffer:
//             reset, single frame, overflow drop, random back-pressure,
//             async reset mid-capture/mid-drain, release/start collision.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_64p_16b_out_buffer;
  import fft_64p_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_64p_16b_out_buffer_if bus();

  fft_64p_16b_out_buffer #(.DATA_W(FFT_DATA_W), .N_LOG2(FFT_N_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // consumer ready: 0 = stall, 1 = always ready, 2 = random 50%
  int   rdy_mode = 0;
  logic rnd_bit  = 1'b0;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
  assign bus.m_ready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 1);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- beat monitor ----------------
  logic [31:0] q_data[$];
  logic [5:0]  q_idx[$];
  logic        q_last[$];
  int          q_cyc[$];
  logic        prev_stall = 1'b0;
  logic [38:0] prev_out   = '0;
  int          stall_err  = 0;
  int          stall_seen = 0;

  always @(negedge clk) begin
    if (rst_n && bus.m_valid) begin
      if (prev_stall) begin
        stall_seen <= stall_seen + 1;
        if ({bus.m_data, bus.m_index, bus.m_last} !== prev_out) stall_err <= stall_err + 1;
      end
      if (bus.m_ready) begin
        q_data.push_back(bus.m_data);
        q_idx.push_back(bus.m_index);
        q_last.push_back(bus.m_last);
        q_cyc.push_back(cyc);
      end
    end
    prev_stall <= rst_n & bus.m_valid & ~bus.m_ready;
    prev_out   <= {bus.m_data, bus.m_index, bus.m_last};
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [31:0] word(input int f, input int k);
    logic [7:0] fb, kb;
    fb = f[7:0];
    kb = k[7:0];
    return {fb, kb, fb, kb};
  endfunction

  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < 6; b++) if (i[b]) r = r | (1 << (5 - b));
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int f, input int i);
`ifdef FFT_OUT_BITREV_EN
    return word(f, brev(i));
`else
    return word(f, i);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives nwords of frame f starting now (caller sits just after a posedge).
  task automatic burst(input int f, input int nwords, output logic ovf0, output int npulse);
    npulse = 0;
    ovf0   = 1'b0;
    for (int k = 0; k < nwords; k++) begin
      bus.Data_Out   = (k == 0);
      bus.Out_Stream = word(f, k);
      @(negedge clk);
      if (bus.ovf_err) npulse++;
      if (k == 0) ovf0 = bus.ovf_err;
      @(posedge clk);
      #1;
    end
    bus.Data_Out   = 1'b0;
    bus.Out_Stream = '0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (q_data.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    chk("beats_available", 32'(q_data.size() >= n), 32'd1);
  endtask

  task automatic check_frame(input int f, input int base);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("f%0d_b%0d_data", f, i), q_data[base+i], exp_word(f, i));
      chk($sformatf("f%0d_b%0d_idx", f, i), 32'(q_idx[base+i]), 32'(i));
      chk($sformatf("f%0d_b%0d_last", f, i), 32'(q_last[base+i]), 32'(i == 63));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(bus.m_valid), 32'd0);
    chk({tag, "_last"}, 32'(bus.m_last), 32'd0);
    chk({tag, "_index"}, 32'(bus.m_index), 32'd0);
    chk({tag, "_data"}, bus.m_data, 32'd0);
    chk({tag, "_ovf"}, 32'(bus.ovf_err), 32'd0);
    chk({tag, "_lost"}, 32'(bus.frames_lost), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic ovf0;
    int   np, np_sum, base, base2;

    bus.Data_Out   = 1'b0;
    bus.Out_Stream = '0;

    // 1: reset, then idle
    tick(3);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    np_sum = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.ovf_err) np_sum++;
      tick(1);
    end
    check_reset_outputs("idle");
    chk("idle_ovf_pulses", 32'(np_sum), 32'd0);

    // 2: one frame, consumer always ready
    rdy_mode = 1;
    base = q_data.size();
    burst(0, 64, ovf0, np);
    chk("t2_ovf", 32'(ovf0), 32'd0);
    @(negedge clk);
    chk("t2_valid_e0", 32'(bus.m_valid), 32'd0);
    tick(1);
    @(negedge clk);
    chk("t2_valid_e1", 32'(bus.m_valid), 32'd0);
    tick(1);
    @(negedge clk);
    chk("t2_valid_e2", 32'(bus.m_valid), 32'd1);
    chk("t2_first_idx", 32'(bus.m_index), 32'd0);
    chk("t2_first_data", bus.m_data, exp_word(0, 0));
    tick(1);
    wait_beats(base + 64, 200);
    check_frame(0, base);
    chk("t2_gapfree", 32'(q_cyc[base+63] - q_cyc[base]), 32'd63);
    chk("t2_lost", 32'(bus.frames_lost), 32'd0);

    // 3: three back-to-back bursts with consumer stalled
    rdy_mode = 0;
    base = q_data.size();
    burst(1, 64, ovf0, np);
    chk("t3_ovf_f1", 32'(ovf0), 32'd0);
    burst(2, 64, ovf0, np);
    chk("t3_ovf_f2", 32'(ovf0), 32'd0);
    burst(3, 64, ovf0, np);
    chk("t3_ovf_f3", 32'(ovf0), 32'd1);
    chk("t3_ovf_pulses", 32'(np), 32'd1);
    chk("t3_lost", 32'(bus.frames_lost), 32'd1);
    chk("t3_stalled_valid", 32'(bus.m_valid), 32'd1);
    chk("t3_no_beats_yet", 32'(q_data.size()), 32'(base));
    rdy_mode = 1;
    wait_beats(base + 128, 400);
    tick(80);
    chk("t3_exact_beats", 32'(q_data.size()), 32'(base + 128));
    check_frame(1, base);
    check_frame(2, base + 64);

    // 4: random back-pressure, four spaced bursts
    rdy_mode = 2;
    base = q_data.size();
    np_sum = 0;
    for (int b = 0; b < 4; b++) begin
      burst(4 + b, 64, ovf0, np);
      np_sum += np;
      tick(150);
    end
    chk("t4_ovf_pulses", 32'(np_sum), 32'd0);
    wait_beats(base + 256, 2000);
    for (int b = 0; b < 4; b++) check_frame(4 + b, base + 64 * b);
    chk("t4_lost", 32'(bus.frames_lost), 32'd1);
    chk("t4_stall_seen", 32'(stall_seen > 0), 32'd1);
    chk("stall_stability", 32'(stall_err), 32'd0);

    // 5: async reset at capture word 30, then mid-drain
    rdy_mode = 1;
    burst(8, 31, ovf0, np);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst_capt");
    tick(3);
    rst_n = 1'b1;
    tick(2);
    base = q_data.size();
    burst(9, 64, ovf0, np);
    wait_beats(base + 10, 50);
    chk("t5_pre_rst_valid", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t5_rst_drain");
    tick(3);
    rst_n = 1'b1;
    tick(1);
    base2 = q_data.size();
    tick(10);
    chk("t5_no_leftover", 32'(q_data.size()), 32'(base2));
    burst(10, 64, ovf0, np);
    chk("t5_ovf", 32'(ovf0), 32'd0);
    wait_beats(base2 + 64, 200);
    tick(20);
    chk("t5_exact_beats", 32'(q_data.size()), 32'(base2 + 64));
    check_frame(10, base2);

    // 6: release of a full bank on the same cycle a new burst starts
    rdy_mode = 0;
    base = q_data.size();
    burst(11, 64, ovf0, np);
    burst(12, 64, ovf0, np);
    tick(4);
    chk("t6_stalled_valid", 32'(bus.m_valid), 32'd1);
    chk("t6_stalled_idx", 32'(bus.m_index), 32'd0);
    rdy_mode = 1;          // word 0 accepted at next edge, word 63 at the 64th
    repeat (63) @(posedge clk);
    #1;
    burst(13, 64, ovf0, np);
    chk("t6_ovf", 32'(ovf0), 32'd0);
    chk("t6_ovf_pulses", 32'(np), 32'd0);
    chk("t6_lost", 32'(bus.frames_lost), 32'd0);
    wait_beats(base + 192, 400);
    chk("t6_release_gapfree", 32'(q_cyc[base+63] - q_cyc[base]), 32'd63);
    check_frame(11, base);
    check_frame(12, base + 64);
    check_frame(13, base + 128);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
